// File: rtl/bcd2_sevenseg_scan.sv
// Two-digit multiplexed 7-segment driver for a common-anode display.
// Inputs are snapshotted once per scan frame; the tens DP blinks while CO is held.
module bcd2_sevenseg_scan #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic       CO,
    input  logic       BLANK_LZ,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_FRAMES - 1);

    typedef enum logic {
        StOnes = 1'b0,
        StTens = 1'b1
    } sel_e;

    sel_e            sel_q, sel_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      s1_q, s1_d;
    logic [3:0]      s2_q, s2_d;
    logic            sco_q, sco_d;
    logic [BlkW-1:0] blk_q, blk_d;
    logic            dpst_q, dpst_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            tick;
    logic            frame_start;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sel_q  <= StOnes;
            cnt_q  <= '0;
            s1_q   <= 4'd0;
            s2_q   <= 4'd0;
            sco_q  <= 1'b0;
            blk_q  <= '0;
            dpst_q <= 1'b0;
            an_q   <= 4'b1110;
            seg_q  <= 7'b1000000;
            dp_q   <= 1'b1;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            sco_q  <= sco_d;
            blk_q  <= blk_d;
            dpst_q <= dpst_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    always_comb begin
        tick        = (cnt_q == CntMax);
        frame_start = tick && (sel_q == StTens);
        cnt_d       = tick ? '0 : cnt_q + CntW'(1);
        sel_d       = sel_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        sco_d       = sco_q;
        blk_d       = blk_q;
        dpst_d      = dpst_q;
        if (tick) begin
            sel_d = (sel_q == StOnes) ? StTens : StOnes;
        end
        if (frame_start) begin
            s1_d  = Q1;
            s2_d  = Q2;
            sco_d = CO;
            if (!CO) begin
                dpst_d = 1'b0;
                blk_d  = '0;
            end else if (!sco_q) begin
                // Fresh CO capture starts with the DP lit.
                dpst_d = 1'b1;
                blk_d  = '0;
            end else if (blk_q == BlkMax) begin
                dpst_d = ~dpst_q;
                blk_d  = '0;
            end else begin
                blk_d = blk_q + BlkW'(1);
            end
        end
    end

    // Outputs follow the new slot; the ones slot uses the snapshot taken on the same edge.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            if (sel_d == StOnes) begin
                an_d  = 4'b1110;
                seg_d = dec(s1_d);
                dp_d  = 1'b1;
            end else begin
                an_d  = (BLANK_LZ && (s2_q == 4'd0)) ? 4'b1111 : 4'b1101;
                seg_d = dec(s2_q);
                dp_d  = ~dpst_q;
            end
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_bcd2_sevenseg_scan.sv
// Bench for bcd2_sevenseg_scan: directed literal checks plus randomized inputs
// compared every cycle against a slot/frame-arithmetic model.
module tb_bcd2_sevenseg_scan;

    localparam int unsigned RD = 4;
    localparam int unsigned BF = 2;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [3:0] Q1 = 4'd0;
    logic [3:0] Q2 = 4'd0;
    logic       CO = 1'b0;
    logic       BLANK_LZ = 1'b0;
    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bcd2_sevenseg_scan #(
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .Q1      (Q1),
        .Q2      (Q2),
        .CO      (CO),
        .BLANK_LZ(BLANK_LZ),
        .SEG     (SEG),
        .DP      (DP),
        .AN      (AN)
    );

    always #5 CLK = ~CLK;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // Model: n = clock edges since reset release; slot m = n/RD, odd slots are tens,
    // even slots start a frame. co_frames = consecutive frame starts that sampled CO=1.
    int         n = 0;
    int         co_frames = 0;
    logic [3:0] ms1 = 4'd0, ms2 = 4'd0;
    logic [3:0] e_an = 4'b1110;
    logic [6:0] e_seg = 7'b1000000;
    logic       e_dp = 1'b1;

    initial begin
        forever begin
            @(posedge CLK or negedge CLR);
            if (!CLR) begin
                n = 0; co_frames = 0; ms1 = 4'd0; ms2 = 4'd0;
                e_an = 4'b1110; e_seg = 7'b1000000; e_dp = 1'b1;
            end else begin
                n++;
                if (n % RD == 0) begin
                    if ((n / RD) % 2 == 0) begin
                        ms1 = Q1;
                        ms2 = Q2;
                        co_frames = CO ? co_frames + 1 : 0;
                        e_an = 4'b1110; e_seg = dec_tab[ms1]; e_dp = 1'b1;
                    end else begin
                        e_seg = dec_tab[ms2];
                        e_an  = (BLANK_LZ && ms2 == 4'd0) ? 4'b1111 : 4'b1101;
                        e_dp  = !(co_frames > 0 && ((co_frames - 1) / BF) % 2 == 0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                checks++;
                if ({AN, SEG, DP} !== {e_an, e_seg, e_dp}) begin
                    errors++;
                    $display("FAIL scan t=%0t n=%0d: got AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=%b",
                             $time, n, AN, SEG, DP, e_an, e_seg, e_dp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp);
        checks++;
        if ({AN, SEG, DP} !== {an, seg, dp}) begin
            errors++;
            $display("FAIL %s: got AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=%b",
                     name, AN, SEG, DP, an, seg, dp);
        end
    endtask

    task automatic goto_edge(input int t);
        int guard = 0;
        while (n < t) begin
            @(negedge CLK);
            guard++;
            if (guard > 500) begin
                checks++;
                errors++;
                $display("FAIL goto_edge: n=%0d never reached %0d", n, t);
                return;
            end
        end
    endtask

    initial begin
        #1 CLR = 1'b0;
        #1 cmp_en = 1'b1;
        // T1 reset
        repeat (3) @(negedge CLK);
        #1 chk("reset_hold", 4'b1110, 7'b1000000, 1'b1);
        @(negedge CLK);
        CLR = 1'b1;
        goto_edge(3);  chk("pre_tick", 4'b1110, 7'b1000000, 1'b1);
        goto_edge(4);  chk("first_tick", 4'b1101, 7'b1000000, 1'b1);
        // T2
        Q2 = 4'd4; Q1 = 4'd7;
        goto_edge(8);  chk("t2_ones7", 4'b1110, 7'b1111000, 1'b1);
        goto_edge(12); chk("t2_tens4", 4'b1101, 7'b0011001, 1'b1);
        // T3
        Q2 = 4'd0; Q1 = 4'd5; BLANK_LZ = 1'b1;
        goto_edge(16); chk("t3_ones5", 4'b1110, 7'b0010010, 1'b1);
        goto_edge(20); chk("t3_blank", 4'b1111, 7'b1000000, 1'b1);
        BLANK_LZ = 1'b0;
        goto_edge(28); chk("t3_noblank", 4'b1101, 7'b1000000, 1'b1);
        // T4 tearing
        Q1 = 4'd3;
        goto_edge(32); chk("t4_ones3", 4'b1110, 7'b0110000, 1'b1);
        goto_edge(37); Q1 = 4'd4;
        goto_edge(39); chk("t4_tens_hold", 4'b1101, 7'b1000000, 1'b1);
        goto_edge(40); chk("t4_ones4", 4'b1110, 7'b0011001, 1'b1);
        // T5 blink
        CO = 1'b1; Q2 = 4'd1; Q1 = 4'd2;
        goto_edge(48); chk("t5_ones_dp", 4'b1110, 7'b0100100, 1'b1);
        goto_edge(52); chk("t5_f0_on", 4'b1101, 7'b1111001, 1'b0);
        goto_edge(60); chk("t5_f1_on", 4'b1101, 7'b1111001, 1'b0);
        goto_edge(68); chk("t5_f2_off", 4'b1101, 7'b1111001, 1'b1);
        goto_edge(76); chk("t5_f3_off", 4'b1101, 7'b1111001, 1'b1);
        goto_edge(84); chk("t5_f4_on", 4'b1101, 7'b1111001, 1'b0);
        goto_edge(85); CO = 1'b0;
        goto_edge(92); chk("t5_co_drop", 4'b1101, 7'b1111001, 1'b1);
        // T6 dash and async reset
        Q1 = 4'hB;
        goto_edge(96); chk("t6_dash", 4'b1110, 7'b0111111, 1'b1);
        goto_edge(98);
        #2 CLR = 1'b0;
        #1 chk("t6_async_rst", 4'b1110, 7'b1000000, 1'b1);
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0)
                Q1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0)
                Q2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) CO = ~CO;
            if ($urandom_range(0, 19) == 0) BLANK_LZ = ~BLANK_LZ;
            if (i == 1500) begin
                #3 CLR = 1'b0;
                repeat (2) @(negedge CLK);
                CLR = 1'b1;
            end
        end
        @(negedge CLK);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
